tile_cfg_loader: RTL

TILE_CFG_LOADER -- requirements
Module: tile_cfg_loader

---
 rtl/tile_cfg_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tile_cfg_loader.sv
// Serial configuration loader: streams cfg words LSB-first into one of CHAIN_NUM
// scan chains, optionally comparing the returned stream against what is sent.
module tile_cfg_loader #(
    parameter int CHAIN_NUM = 2,
    parameter int WORD_W    = 8,
    parameter int LEN_W     = 10,
    parameter int SEL_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     chain_sel,
    input  logic [LEN_W-1:0]     chain_len,
    input  logic                 verify,
    input  logic [WORD_W-1:0]    cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [CHAIN_NUM-1:0] scan_in_bus,
    output logic [CHAIN_NUM-1:0] scan_en_bus,
    input  logic [CHAIN_NUM-1:0] scan_out_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic                 cfg_err
);
    localparam int BIT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [LEN_W-1:0]  r_rem;
    logic              r_verify;
    logic [WORD_W-1:0] r_sreg;
    logic [BIT_W-1:0]  r_word_bits;
    logic              r_mismatch;
    logic              r_cfg_err;

    logic w_accept;
    logic w_sel_bad;
    logic w_handshake;
    logic w_shift;
    logic w_ret_bit;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_sel_bad   = (32'(chain_sel) >= 32'(CHAIN_NUM));
    assign w_handshake = (r_state == LOAD) && cfg_valid;
    assign w_shift     = (r_state == SHIFT);

    assign mismatch = r_mismatch;
    assign cfg_err  = r_cfg_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // Illegal or empty jobs finish without touching any chain.
                    if (w_sel_bad || (chain_len == '0)) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_rem <= LEN_W'(1)) begin
                    w_state_nxt = FIN;
                end else if (r_word_bits <= BIT_W'(1)) begin
                    w_state_nxt = LOAD;
                end
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        scan_en_bus = '0;
        scan_in_bus = '0;
        w_ret_bit   = 1'b0;
        for (int unsigned i = 0; i < CHAIN_NUM; i++) begin
            if (r_sel == SEL_W'(i)) begin
                scan_en_bus[i] = w_shift;
                scan_in_bus[i] = w_shift & r_sreg[0];
                w_ret_bit      = scan_out_bus[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_rem       <= '0;
            r_verify    <= 1'b0;
            r_sreg      <= '0;
            r_word_bits <= '0;
            r_mismatch  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel      <= chain_sel;
                r_rem      <= chain_len;
                r_verify   <= verify;
                r_mismatch <= 1'b0;
                r_cfg_err  <= w_sel_bad;
            end
            if (w_handshake) begin
                r_sreg      <= cfg_data;
                r_word_bits <= BIT_W'(WORD_W);
            end
            if (w_shift) begin
                r_sreg <= r_sreg >> 1;
                if (r_rem != '0) begin
                    r_rem <= r_rem - 1'b1;
                end
                if (r_word_bits != '0) begin
                    r_word_bits <= r_word_bits - 1'b1;
                end
                // Verify re-sends the expected image, so chain contents survive the pass.
                if (r_verify && (w_ret_bit != r_sreg[0])) begin
                    r_mismatch <= 1'b1;
                end
            end
        end
    end

endmodule
